// File: rtl/axi4_pkg.sv
// Shared AXI4 types for the SRAM slave.
//   axi4_burst_e : AxBURST encodings (FIXED/INCR/WRAP plus the reserved code)
//   RESP_*       : xRESP encodings
//   w_state_e    : write-channel FSM states
//   r_state_e    : read-channel FSM states
//   wrap_len_ok  : WRAP bursts are only legal with 2, 4, 8 or 16 beats
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi4_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI4_MAX_BURST = 256;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 link carrying the full AW/W/B/AR/R channel set.
//   slave modport  : responder end (drives the READY/B/R side)
//   master modport : requester end
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4
);
  logic [AXI4_ID_WIDTH-1:0]        awid;
  logic [AXI4_ADDRESS_WIDTH-1:0]   awaddr;
  logic [7:0]                      awlen;
  logic [2:0]                      awsize;
  logic [1:0]                      awburst;
  logic                            awvalid;
  logic                            awready;

  logic [AXI4_DATA_WIDTH-1:0]      wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]    wstrb;
  logic                            wlast;
  logic                            wvalid;
  logic                            wready;

  logic [AXI4_ID_WIDTH-1:0]        bid;
  logic [1:0]                      bresp;
  logic                            bvalid;
  logic                            bready;

  logic [AXI4_ID_WIDTH-1:0]        arid;
  logic [AXI4_ADDRESS_WIDTH-1:0]   araddr;
  logic [7:0]                      arlen;
  logic [2:0]                      arsize;
  logic [1:0]                      arburst;
  logic                            arvalid;
  logic                            arready;

  logic [AXI4_ID_WIDTH-1:0]        rid;
  logic [AXI4_DATA_WIDTH-1:0]      rdata;
  logic [1:0]                      rresp;
  logic                            rlast;
  logic                            rvalid;
  logic                            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for one AXI4 burst.
//   addr_i      : address of the current beat
//   size_i      : AxSIZE (bytes per beat = 2**size)
//   len_i       : AxLEN (beats - 1)
//   burst_i     : AxBURST
//   next_addr_o : address of the following beat
//   illegal_o   : size wider than the data bus, reserved burst type,
//                 or a WRAP length other than 2/4/8/16 beats
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int MAX_SIZE           = 2
) (
  input  logic [AXI4_ADDRESS_WIDTH-1:0] addr_i,
  input  logic [2:0]                    size_i,
  input  logic [7:0]                    len_i,
  input  logic [1:0]                    burst_i,
  output logic [AXI4_ADDRESS_WIDTH-1:0] next_addr_o,
  output logic                          illegal_o
);
  localparam int AW = AXI4_ADDRESS_WIDTH;

  logic [AW-1:0] step;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;

  always_comb begin
    step      = AW'(1) << size_i;
    incr_addr = addr_i + step;
    // Wrap window is (len+1)*2**size bytes, always a power of two when legal.
    wrap_mask = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);

    next_addr_o = incr_addr;
    illegal_o   = (size_i > 3'(MAX_SIZE));

    case (axi4_burst_e'(burst_i))
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP: begin
        next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
        if (!wrap_len_ok(len_i)) illegal_o = 1'b1;
      end
      default: begin
        // Reserved type still advances like INCR so the beats are consumed.
        next_addr_o = incr_addr;
        illegal_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a single-port-per-channel SRAM array.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (memory contents are kept)
//   slave : AXI4 responder port, independent write (AW/W/B) and read (AR/R)
// Out-of-range beats are dropped on write and read back as zero; any burst
// anomaly is reported as SLVERR.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int MEM_DEPTH_WORDS    = 1024
) (
  input logic   clk,
  input logic   rst,
  axi4_if.slave slave
);
  localparam int AW    = AXI4_ADDRESS_WIDTH;
  localparam int DW    = AXI4_DATA_WIDTH;
  localparam int IW    = AXI4_ID_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

  logic [DW-1:0] mem_q [MEM_DEPTH_WORDS];

  // ---------------- write channel ----------------
  w_state_e      w_state_q, w_state_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;
  logic [IW-1:0] aw_id_q, aw_id_d;
  logic [7:0]    aw_len_q, aw_len_d;
  logic [2:0]    aw_size_q, aw_size_d;
  logic [1:0]    aw_burst_q, aw_burst_d;
  logic [7:0]    w_cnt_q, w_cnt_d;
  logic          w_err_q, w_err_d;

  logic [AW-1:0]    w_next_addr;
  logic             w_illegal;
  logic [AW-1:0]    w_word;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_last_beat;
  logic             mem_we;
  logic             awready, wready, bvalid;

  axi4_burst_addr_gen #(
    .AXI4_ADDRESS_WIDTH(AW),
    .MAX_SIZE          (SHIFT)
  ) u_w_addr_gen (
    .addr_i     (aw_addr_q),
    .size_i     (aw_size_q),
    .len_i      (aw_len_q),
    .burst_i    (aw_burst_q),
    .next_addr_o(w_next_addr),
    .illegal_o  (w_illegal)
  );

  assign w_word      = aw_addr_q >> SHIFT;
  assign w_in_range  = (w_word < AW'(MEM_DEPTH_WORDS));
  assign w_idx       = w_word[IDX_W-1:0];
  assign w_last_beat = (w_cnt_q == aw_len_q);

  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    mem_we     = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        awready = !rst;
        if (slave.awvalid && !rst) begin
          aw_addr_d  = slave.awaddr;
          aw_id_d    = slave.awid;
          aw_len_d   = slave.awlen;
          aw_size_d  = slave.awsize;
          aw_burst_d = slave.awburst;
          w_cnt_d    = 8'd0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (slave.wvalid) begin
          mem_we = w_in_range && !rst;
          // WLAST must line up exactly with the AWLEN-th beat.
          if (!w_in_range || w_illegal || (slave.wlast != w_last_beat)) w_err_d = 1'b1;
          aw_addr_d = w_next_addr;
          w_cnt_d   = w_cnt_q + 8'd1;
          if (w_last_beat) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (slave.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
    end
  end

  // Storage has no reset; byte lanes follow WSTRB.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (slave.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= slave.wdata[b*8 +: 8];
      end
    end
  end

  assign slave.awready = awready;
  assign slave.wready  = wready;
  assign slave.bvalid  = bvalid;
  assign slave.bid     = aw_id_q;
  assign slave.bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  r_state_e      r_state_q, r_state_d;
  logic [AW-1:0] ar_addr_q, ar_addr_d;
  logic [IW-1:0] ar_id_q, ar_id_d;
  logic [7:0]    ar_len_q, ar_len_d;
  logic [2:0]    ar_size_q, ar_size_d;
  logic [1:0]    ar_burst_q, ar_burst_d;
  logic [7:0]    r_cnt_q, r_cnt_d;

  logic [AW-1:0]    r_next_addr;
  logic             r_illegal;
  logic [AW-1:0]    r_word;
  logic             r_in_range;
  logic [IDX_W-1:0] r_idx;
  logic             r_last_beat;
  logic             arready, rvalid;

  axi4_burst_addr_gen #(
    .AXI4_ADDRESS_WIDTH(AW),
    .MAX_SIZE          (SHIFT)
  ) u_r_addr_gen (
    .addr_i     (ar_addr_q),
    .size_i     (ar_size_q),
    .len_i      (ar_len_q),
    .burst_i    (ar_burst_q),
    .next_addr_o(r_next_addr),
    .illegal_o  (r_illegal)
  );

  assign r_word      = ar_addr_q >> SHIFT;
  assign r_in_range  = (r_word < AW'(MEM_DEPTH_WORDS));
  assign r_idx       = r_word[IDX_W-1:0];
  assign r_last_beat = (r_cnt_q == ar_len_q);

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    arready    = 1'b0;
    rvalid     = 1'b0;

    case (r_state_q)
      R_IDLE: begin
        arready = !rst;
        if (slave.arvalid && !rst) begin
          ar_addr_d  = slave.araddr;
          ar_id_d    = slave.arid;
          ar_len_d   = slave.arlen;
          ar_size_d  = slave.arsize;
          ar_burst_d = slave.arburst;
          r_cnt_d    = 8'd0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (slave.rready) begin
          ar_addr_d = r_next_addr;
          r_cnt_d   = r_cnt_q + 8'd1;
          if (r_last_beat) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  // Read data is taken straight from the array, so a write landing on the
  // same edge is seen only from the following cycle.
  assign slave.arready = arready;
  assign slave.rvalid  = rvalid;
  assign slave.rid     = ar_id_q;
  assign slave.rlast   = rvalid && r_last_beat;
  assign slave.rdata   = (rvalid && r_in_range) ? mem_q[r_idx] : '0;
  assign slave.rresp   = (rvalid && (r_illegal || !r_in_range)) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_sram_slave.sv
module tb_axi4_sram_slave;
  logic clk;
  logic rst;

  axi4_if #(.AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(4)) bus ();

  axi4_sram_slave #(
    .AXI4_ADDRESS_WIDTH(32),
    .AXI4_DATA_WIDTH   (32),
    .AXI4_ID_WIDTH     (4),
    .MEM_DEPTH_WORDS   (1024)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .slave(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.awready;
      1:       return bus.wready;
      2:       return bus.bvalid;
      3:       return bus.arready;
      default: return bus.rvalid;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the selected signal high.
  task automatic wait_for(input int sel);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL timeout waiting on handshake %0d", sel);
    end
  endtask

  logic [31:0] wr_data [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id;
  int          stall_diff;
  int          stall_valid_drop;

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input bit drop_wlast,
                           output logic [1:0] resp, output logic [3:0] bid);
    @(negedge clk);
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = burst;
    bus.awvalid = 1'b1;
    wait_for(0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = wr_data[i];
      bus.wstrb  = strb;
      bus.wlast  = drop_wlast ? 1'b0 : (i == int'(len));
      wait_for(1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    wait_for(2);
    resp = bus.bresp;
    bid  = bus.bid;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat);
    logic [31:0] s_data;
    logic        s_last;
    @(negedge clk);
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst;
    bus.arvalid = 1'b1;
    wait_for(3);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        bus.rready = 1'b0;
        s_data = bus.rdata;
        s_last = bus.rlast;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (bus.rdata !== s_data || bus.rlast !== s_last) stall_diff++;
          if (bus.rvalid !== 1'b1) stall_valid_drop++;
        end
      end
      bus.rready = 1'b1;
      wait_for(4);
      rd_data[i] = bus.rdata;
      rd_resp[i] = bus.rresp;
      rd_last[i] = bus.rlast;
      if (i == 0) rd_id = bus.rid;
      @(posedge clk);
      @(negedge clk);
    end
    bus.rready = 1'b0;
  endtask

  typedef struct {
    string            nm;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [3:0][31:0] exp_data;
    logic [1:0]       exp_resp;
  } rvec_t;

  rvec_t rv [8];
  int    n_rv = 0;

  task automatic add_rv(input string nm, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [3:0][31:0] d, input logic [1:0] resp);
    rv[n_rv].nm       = nm;
    rv[n_rv].addr     = addr;
    rv[n_rv].len      = len;
    rv[n_rv].burst    = burst;
    rv[n_rv].exp_data = d;
    rv[n_rv].exp_resp = resp;
    n_rv++;
  endtask

  logic [1:0] resp;
  logic [3:0] bid;

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    stall_diff = 0;
    stall_valid_drop = 0;

    // Expected read results, all hand-computed from the writes below.
    add_rv("incr_1to4",  32'h10,   8'd3, 2'b01, {32'd4, 32'd3, 32'd2, 32'd1}, 2'b00);
    add_rv("wrap_0x38",  32'h38,   8'd3, 2'b10, {32'h34, 32'h30, 32'h3C, 32'h38}, 2'b00);
    add_rv("strb_merge", 32'h40,   8'd0, 2'b01, {96'h0, 32'h1122CCDD}, 2'b00);
    add_rv("oor_read",   32'h1000, 8'd0, 2'b01, {96'h0, 32'h0}, 2'b10);
    add_rv("word0_kept", 32'h0,    8'd0, 2'b01, {96'h0, 32'hCAFEF00D}, 2'b00);
    add_rv("fixed_0x14", 32'h14,   8'd2, 2'b00, {32'h0, 32'd2, 32'd2, 32'd2}, 2'b00);
    add_rv("nolast_dat", 32'h50,   8'd1, 2'b01, {64'h0, 32'h5B, 32'h5A}, 2'b00);
    add_rv("rsvd_read",  32'h70,   8'd1, 2'b11, {64'h0, 32'd8, 32'd7}, 2'b10);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_wready",  bus.wready, 0);
    check("rst_bvalid",  bus.bvalid, 0);
    check("rst_rvalid",  bus.rvalid, 0);
    check("rst_rlast",   bus.rlast, 0);
    check("rst_bid_bresp", {bus.bid, bus.bresp}, 0);
    check("rst_rid_rresp", {bus.rid, bus.rresp}, 0);
    check("rst_rdata",   bus.rdata, 0);
    rst = 1'b0;
    #1;
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_arready", bus.arready, 1);

    wr_data[0] = 32'hCAFEF00D;
    axi_write(32'h0, 4'd1, 8'd0, 2'b01, 4'hF, 1'b0, resp, bid);
    check("w_word0_resp", resp, 2'b00);

    for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
    axi_write(32'h10, 4'd5, 8'd3, 2'b01, 4'hF, 1'b0, resp, bid);
    check("w_incr_resp", resp, 2'b00);
    check("w_incr_bid", bid, 4'd5);

    for (int i = 0; i < 4; i++) wr_data[i] = 32'h30 + 32'(4 * i);
    axi_write(32'h30, 4'd2, 8'd3, 2'b01, 4'hF, 1'b0, resp, bid);
    check("w_preload_resp", resp, 2'b00);

    wr_data[0] = 32'h11223344;
    axi_write(32'h40, 4'd3, 8'd0, 2'b01, 4'hF, 1'b0, resp, bid);
    wr_data[0] = 32'hAABBCCDD;
    axi_write(32'h40, 4'd3, 8'd0, 2'b01, 4'h3, 1'b0, resp, bid);
    check("w_strb_resp", resp, 2'b00);

    wr_data[0] = 32'hDEADBEEF;
    axi_write(32'h1000, 4'd9, 8'd0, 2'b01, 4'hF, 1'b0, resp, bid);
    check("w_oor_resp", resp, 2'b10);
    check("w_oor_bid", bid, 4'd9);

    wr_data[0] = 32'h5A; wr_data[1] = 32'h5B;
    axi_write(32'h50, 4'd4, 8'd1, 2'b01, 4'hF, 1'b1, resp, bid);
    check("w_nolast_resp", resp, 2'b10);

    wr_data[0] = 32'd7; wr_data[1] = 32'd8;
    axi_write(32'h70, 4'd6, 8'd1, 2'b11, 4'hF, 1'b0, resp, bid);
    check("w_rsvd_resp", resp, 2'b10);

    for (int v = 0; v < n_rv; v++) begin
      axi_read(rv[v].addr, 4'(v), rv[v].len, rv[v].burst, -1);
      check({rv[v].nm, "_rid"}, rd_id, 4'(v));
      for (int i = 0; i <= int'(rv[v].len); i++) begin
        check({rv[v].nm, "_data"}, rd_data[i], rv[v].exp_data[i]);
        check({rv[v].nm, "_resp"}, rd_resp[i], rv[v].exp_resp);
        check({rv[v].nm, "_last"}, rd_last[i], (i == int'(rv[v].len)));
      end
    end

    // RREADY held low for 5 cycles before beat 2.
    axi_read(32'h10, 4'd7, 8'd3, 2'b01, 2);
    check("stall_stable", 64'(stall_diff), 0);
    check("stall_rvalid", 64'(stall_valid_drop), 0);
    for (int i = 0; i < 4; i++) check("stall_data", rd_data[i], 32'(i + 1));
    check("stall_last3", rd_last[3], 1);

    // Read parked on word 0x60 while a write to that word completes.
    wr_data[0] = 32'h1111;
    axi_write(32'h60, 4'd1, 8'd0, 2'b01, 4'hF, 1'b0, resp, bid);
    @(negedge clk);
    bus.araddr = 32'h60; bus.arid = 4'd3; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    wait_for(3);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rw_pre_data", bus.rdata, 32'h1111);
    wr_data[0] = 32'h2222;
    axi_write(32'h60, 4'd1, 8'd0, 2'b01, 4'hF, 1'b0, resp, bid);
    check("rw_wr_resp", resp, 2'b00);
    check("rw_post_data", bus.rdata, 32'h2222);
    check("rw_rvalid_held", bus.rvalid, 1);
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    check("rw_read_done", bus.rvalid, 0);

    // Reset during beat 2 of an 8-beat write.
    @(negedge clk);
    bus.awaddr = 32'h80; bus.awid = 4'd2; bus.awlen = 8'd7; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awvalid = 1'b1;
    wait_for(0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = 32'hA0 + 32'(i);
      bus.wstrb  = 4'hF;
      bus.wlast  = 1'b0;
      if (i == 2) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_bvalid", bus.bvalid, 0);
    rst = 1'b0;
    #1;
    check("midrst_awready", bus.awready, 1);
    check("midrst_bvalid_after", bus.bvalid, 0);
    bus.bready = 1'b0;
    axi_read(32'h80, 4'd1, 8'd1, 2'b01, -1);
    check("midrst_beat0", rd_data[0], 32'hA0);
    check("midrst_beat1", rd_data[1], 32'hA1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
